pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Single-entry pipeline stage with a skid register so in_ready/out_valid are pure state decodes.
// Counts output-stall cycles in a saturating 8-bit counter; flush empties the stage.
module pipe_skid_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [7:0]       stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Registers keep their contents; only the state forgets them.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 8'hff)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        out_data  = main_q;
        stall_cnt = stall_cnt_q;
    end

endmodule
